// File: rtl/l2_pkg.sv
// rtl/l2_pkg.sv - shared types, widths and MESI transition helpers for the L2 set array
package l2_pkg;

  localparam int L2_INDEX_BITS  = 14;
  localparam int L2_TAG_BITS    = 12;
  localparam int L2_OFFSET_BITS = 6;
  localparam int L2_WAYS        = 8;

  typedef enum logic [2:0] {
    OP_LOOKUP      = 3'd0,
    OP_WRITE_TAG   = 3'd1,
    OP_TOUCH_LRU   = 3'd2,
    OP_UPDATE_MESI = 3'd3,
    OP_FIND_VICTIM = 3'd4,
    OP_EVICT       = 3'd5
  } l2_op_e;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_e;

  typedef enum logic [1:0] {
    SNOOP_NOHIT = 2'd0,
    SNOOP_HIT   = 2'd1,
    SNOOP_HITM  = 2'd2
  } snoop_e;

  localparam logic [3:0] CMD_L1_READ    = 4'd0;
  localparam logic [3:0] CMD_L1_WRITE   = 4'd1;
  localparam logic [3:0] CMD_IFETCH     = 4'd2;
  localparam logic [3:0] CMD_SNP_INV    = 4'd3;
  localparam logic [3:0] CMD_SNP_READ   = 4'd4;
  localparam logic [3:0] CMD_SNP_WRITE  = 4'd5;
  localparam logic [3:0] CMD_SNP_RWIM   = 4'd6;

  // A local miss fill lands in S when another cache holds the line, otherwise E.
  function automatic mesi_e mesi_next(input mesi_e cur, input logic [3:0] cmd,
                                      input logic [1:0] snoop);
    mesi_e nxt;
    nxt = cur;
    case (cmd)
      CMD_L1_READ, CMD_IFETCH: begin
        if (cur == MESI_I) begin
          nxt = (snoop == SNOOP_HIT || snoop == SNOOP_HITM) ? MESI_S : MESI_E;
        end
      end
      CMD_L1_WRITE: nxt = MESI_M;
      CMD_SNP_READ: begin
        if (cur == MESI_M || cur == MESI_E) begin
          nxt = MESI_S;
        end
      end
      CMD_SNP_INV, CMD_SNP_WRITE, CMD_SNP_RWIM: nxt = MESI_I;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  function automatic logic [3:0] first_set8(input logic [7:0] vec);
    logic [3:0] res;
    res = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) begin
        res = {1'b1, 3'(i)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/l2_plru8.sv
// rtl/l2_plru8.sv - 8-way tree pseudo-LRU update and victim selection (combinational)
module l2_plru8 (
  input  logic [6:0] bits_i,
  input  logic [2:0] access_way_i,
  output logic [6:0] bits_o,
  output logic [2:0] victim_o
);

  logic [2:0] upd_l1_idx;
  logic [2:0] upd_l2_idx;
  logic [2:0] vic_l1_idx;
  logic [2:0] vic_l2_idx;
  logic       v2;
  logic       v1;

  // Each tree bit points away from the most recently touched half.
  always_comb begin
    upd_l1_idx = 3'd1 + {2'b00, access_way_i[2]};
    upd_l2_idx = 3'd3 + {1'b0, access_way_i[2], 1'b0} + {2'b00, access_way_i[1]};
    bits_o             = bits_i;
    bits_o[0]          = ~access_way_i[2];
    bits_o[upd_l1_idx] = ~access_way_i[1];
    bits_o[upd_l2_idx] = ~access_way_i[0];
  end

  always_comb begin
    v2         = bits_i[0];
    vic_l1_idx = 3'd1 + {2'b00, v2};
    v1         = bits_i[vic_l1_idx];
    vic_l2_idx = 3'd3 + {1'b0, v2, 1'b0} + {2'b00, v1};
    victim_o   = {v2, v1, bits_i[vic_l2_idx]};
  end

endmodule

// File: rtl/l2_set_array.sv
// rtl/l2_set_array.sv - 8-way L2 tag/MESI/PLRU store serving one controller operation per cycle
module l2_set_array
  import l2_pkg::*;
#(
  parameter int INDEX_BITS = L2_INDEX_BITS,
  parameter int TAG_BITS   = L2_TAG_BITS,
  parameter int WAYS       = L2_WAYS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [2:0]            req_op,
  input  logic [INDEX_BITS-1:0] req_index,
  input  logic [2:0]            req_way,
  input  logic [TAG_BITS-1:0]   req_tag,
  input  logic [3:0]            req_cmd,
  input  logic [1:0]            snoop_result,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic [2:0]            resp_way,
  output logic [1:0]            resp_mesi,
  output logic [TAG_BITS-1:0]   resp_tag
);

  localparam int SETS = 1 << INDEX_BITS;

  logic [TAG_BITS-1:0] tag_q  [SETS][WAYS];
  mesi_e               mesi_q [SETS][WAYS];
  logic [6:0]          plru_q [SETS];

  logic [7:0]          set_valid;
  logic [7:0]          set_match;
  logic [3:0]          hit_enc;
  logic [3:0]          inv_enc;
  logic [6:0]          plru_cur;
  logic [6:0]          plru_upd;
  logic [2:0]          plru_victim;

  logic                tag_wr_en;
  logic                mesi_wr_en;
  logic                plru_wr_en;
  mesi_e               mesi_wr_val;

  logic                resp_valid_d, resp_valid_q;
  logic                resp_hit_d,   resp_hit_q;
  logic [2:0]          resp_way_d,   resp_way_q;
  mesi_e               resp_mesi_d,  resp_mesi_q;
  logic [TAG_BITS-1:0] resp_tag_d,   resp_tag_q;

  always_comb begin
    set_valid = '0;
    set_match = '0;
    for (int w = 0; w < WAYS; w++) begin
      set_valid[w] = (mesi_q[req_index][w] != MESI_I);
      set_match[w] = set_valid[w] && (tag_q[req_index][w] == req_tag);
    end
    hit_enc = first_set8(set_match);
    inv_enc = first_set8(~set_valid);
  end

  assign plru_cur = plru_q[req_index];

  l2_plru8 u_plru (
    .bits_i       (plru_cur),
    .access_way_i (req_way),
    .bits_o       (plru_upd),
    .victim_o     (plru_victim)
  );

  always_comb begin
    resp_valid_d = req_valid;
    resp_hit_d   = 1'b0;
    resp_way_d   = 3'd0;
    resp_mesi_d  = MESI_I;
    resp_tag_d   = '0;
    tag_wr_en    = 1'b0;
    mesi_wr_en   = 1'b0;
    plru_wr_en   = 1'b0;
    mesi_wr_val  = MESI_I;
    if (req_valid) begin
      case (req_op)
        OP_LOOKUP: begin
          if (hit_enc[3]) begin
            resp_hit_d  = 1'b1;
            resp_way_d  = hit_enc[2:0];
            resp_mesi_d = mesi_q[req_index][hit_enc[2:0]];
            resp_tag_d  = tag_q[req_index][hit_enc[2:0]];
          end
        end
        OP_WRITE_TAG: begin
          tag_wr_en   = 1'b1;
          resp_way_d  = req_way;
          resp_mesi_d = mesi_q[req_index][req_way];
          resp_tag_d  = req_tag;
        end
        OP_TOUCH_LRU: begin
          plru_wr_en  = 1'b1;
          resp_way_d  = req_way;
          resp_mesi_d = mesi_q[req_index][req_way];
          resp_tag_d  = tag_q[req_index][req_way];
        end
        OP_UPDATE_MESI: begin
          mesi_wr_en  = 1'b1;
          mesi_wr_val = mesi_next(mesi_q[req_index][req_way], req_cmd, snoop_result);
          resp_way_d  = req_way;
          resp_mesi_d = mesi_wr_val;
          resp_tag_d  = tag_q[req_index][req_way];
        end
        OP_FIND_VICTIM: begin
          // Empty ways are always preferred over displacing a live line.
          resp_way_d  = inv_enc[3] ? inv_enc[2:0] : plru_victim;
          resp_mesi_d = mesi_q[req_index][resp_way_d];
          resp_tag_d  = tag_q[req_index][resp_way_d];
        end
        OP_EVICT: begin
          mesi_wr_en  = 1'b1;
          mesi_wr_val = MESI_I;
          resp_way_d  = req_way;
          resp_tag_d  = tag_q[req_index][req_way];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_way_q   <= 3'd0;
      resp_mesi_q  <= MESI_I;
      resp_tag_q   <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_way_q   <= resp_way_d;
      resp_mesi_q  <= resp_mesi_d;
      resp_tag_q   <= resp_tag_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        plru_q[s] <= 7'd0;
        for (int w = 0; w < WAYS; w++) begin
          mesi_q[s][w] <= MESI_I;
        end
      end
    end else begin
      if (mesi_wr_en) begin
        mesi_q[req_index][req_way] <= mesi_wr_val;
      end
      if (plru_wr_en) begin
        plru_q[req_index] <= plru_upd;
      end
    end
  end

  // Tags carry no reset; a write arriving while reset is asserted is discarded.
  always_ff @(posedge clk) begin
    if (rst_n && tag_wr_en) begin
      tag_q[req_index][req_way] <= req_tag;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign resp_way   = resp_way_q;
  assign resp_mesi  = resp_mesi_q;
  assign resp_tag   = resp_tag_q;

endmodule

// File: tb/tb_l2_set_array.sv
// tb/tb_l2_set_array.sv - directed vectors for the L2 set array
module tb_l2_set_array;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [13:0] req_index;
  logic [2:0]  req_way;
  logic [11:0] req_tag;
  logic [3:0]  req_cmd;
  logic [1:0]  snoop_result;
  logic        resp_valid;
  logic        resp_hit;
  logic [2:0]  resp_way;
  logic [1:0]  resp_mesi;
  logic [11:0] resp_tag;

  int vecs = 0;
  int errs = 0;

  l2_set_array dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_index    (req_index),
    .req_way      (req_way),
    .req_tag      (req_tag),
    .req_cmd      (req_cmd),
    .snoop_result (snoop_result),
    .resp_valid   (resp_valid),
    .resp_hit     (resp_hit),
    .resp_way     (resp_way),
    .resp_mesi    (resp_mesi),
    .resp_tag     (resp_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic do_op(input logic [2:0] op, input logic [13:0] idx, input logic [2:0] way,
                       input logic [11:0] tag, input logic [3:0] cmd, input logic [1:0] snp);
    req_valid    = 1'b1;
    req_op       = op;
    req_index    = idx;
    req_way      = way;
    req_tag      = tag;
    req_cmd      = cmd;
    snoop_result = snp;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic lookup(input logic [13:0] idx, input logic [11:0] tag);
    do_op(3'd0, idx, 3'd0, tag, 4'd0, 2'd0);
  endtask
  task automatic wtag(input logic [13:0] idx, input logic [2:0] way, input logic [11:0] tag);
    do_op(3'd1, idx, way, tag, 4'd0, 2'd0);
  endtask
  task automatic touch(input logic [13:0] idx, input logic [2:0] way);
    do_op(3'd2, idx, way, 12'd0, 4'd0, 2'd0);
  endtask
  task automatic upd(input logic [13:0] idx, input logic [2:0] way, input logic [3:0] cmd,
                     input logic [1:0] snp);
    do_op(3'd3, idx, way, 12'd0, cmd, snp);
  endtask
  task automatic victim(input logic [13:0] idx);
    do_op(3'd4, idx, 3'd0, 12'd0, 4'd0, 2'd0);
  endtask
  task automatic evict(input logic [13:0] idx, input logic [2:0] way);
    do_op(3'd5, idx, way, 12'd0, 4'd0, 2'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_index = '0; req_way = '0;
    req_tag = '0; req_cmd = '0; snoop_result = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", resp_valid, 0);
    chk("rst_hit", resp_hit, 0);
    chk("rst_way", resp_way, 0);
    chk("rst_mesi", resp_mesi, 0);
    chk("rst_tag", resp_tag, 0);
    rst_n = 1'b1;

    victim(14'd0);
    chk("empty_vic_valid", resp_valid, 1);
    chk("empty_vic_way", resp_way, 0);
    lookup(14'd0, 12'h111);
    chk("empty_lookup_hit", resp_hit, 0);
    @(posedge clk); #1;
    chk("valid_one_cycle", resp_valid, 0);

    for (int i = 0; i < 8; i++) begin
      wtag(14'd0, 3'(i), 12'(i));
      touch(14'd0, 3'(i));
      upd(14'd0, 3'(i), 4'd0, 2'd0);
      chk("fill_mesi_E", resp_mesi, 2);
    end
    victim(14'd0);
    chk("full_vic_way", resp_way, 0);
    chk("full_vic_tag", resp_tag, 0);
    evict(14'd0, 3'd0);
    chk("evict_mesi", resp_mesi, 0);
    lookup(14'd0, 12'd0);
    chk("evicted_lookup_hit", resp_hit, 0);
    lookup(14'd0, 12'd3);
    chk("lookup3_hit", resp_hit, 1);
    chk("lookup3_way", resp_way, 3);
    chk("lookup3_mesi", resp_mesi, 2);
    victim(14'd0);
    chk("inv_vic_way", resp_way, 0);

    wtag(14'd5, 3'd2, 12'h111);
    upd(14'd5, 3'd2, 4'd0, 2'd1);
    chk("rd_hit_S", resp_mesi, 1);
    upd(14'd5, 3'd2, 4'd1, 2'd0);
    chk("wr_M", resp_mesi, 3);
    lookup(14'd5, 12'h111);
    chk("lk5_hit", resp_hit, 1);
    chk("lk5_way", resp_way, 2);
    chk("lk5_tag", resp_tag, 12'h111);
    upd(14'd5, 3'd2, 4'd4, 2'd0);
    chk("snprd_S", resp_mesi, 1);
    upd(14'd5, 3'd2, 4'd6, 2'd0);
    chk("rwim_I", resp_mesi, 0);
    upd(14'd5, 3'd2, 4'd4, 2'd0);
    chk("snprd_I_stays", resp_mesi, 0);
    upd(14'd5, 3'd2, 4'd2, 2'd0);
    chk("ifetch_nohit_E", resp_mesi, 2);
    upd(14'd5, 3'd2, 4'd0, 2'd2);
    chk("rd_E_stays", resp_mesi, 2);
    upd(14'd5, 3'd2, 4'd3, 2'd0);
    chk("snpinv_I", resp_mesi, 0);
    upd(14'd5, 3'd2, 4'd9, 2'd0);
    chk("cmd9_unchanged", resp_mesi, 0);
    wtag(14'd5, 3'd6, 12'h111);
    upd(14'd5, 3'd6, 4'd1, 2'd0);
    lookup(14'd5, 12'h111);
    chk("lk_only6_way", resp_way, 6);
    upd(14'd5, 3'd2, 4'd1, 2'd0);
    lookup(14'd5, 12'h111);
    chk("lk_lowest_way", resp_way, 2);

    for (int i = 0; i < 8; i++) begin
      wtag(14'd9, 3'(i), 12'h020 + 12'(i));
      upd(14'd9, 3'(i), 4'd1, 2'd0);
    end
    for (int i = 7; i >= 0; i--) touch(14'd9, 3'(i));
    victim(14'd9);
    chk("desc_vic_way", resp_way, 7);
    chk("desc_vic_tag", resp_tag, 12'h027);
    chk("desc_vic_mesi", resp_mesi, 3);

    for (int i = 0; i < 8; i++) begin
      wtag(14'd10, 3'(i), 12'h040 + 12'(i));
      upd(14'd10, 3'(i), 4'd0, 2'd0);
    end
    for (int i = 0; i < 8; i += 2) touch(14'd10, 3'(i));
    victim(14'd10);
    chk("even_vic_way", resp_way, 1);

    do_op(3'd7, 14'd9, 3'd3, 12'hfff, 4'd1, 2'd0);
    chk("rsvd_valid", resp_valid, 1);
    chk("rsvd_way", resp_way, 0);
    chk("rsvd_tag", resp_tag, 0);
    lookup(14'd9, 12'h027);
    chk("rsvd_no_effect_mesi", resp_mesi, 3);

    lookup(14'd9, 12'h025);
    chk("pre_rst_valid", resp_valid, 1);
    req_valid = 1'b1; req_op = 3'd3; req_index = 14'd10; req_way = 3'd0; req_cmd = 4'd1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", resp_valid, 0);
    chk("async_rst_hit", resp_hit, 0);
    @(posedge clk); #1;
    chk("rst_drop_valid", resp_valid, 0);
    req_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    victim(14'd9);
    chk("post_rst_vic_way", resp_way, 0);
    chk("post_rst_vic_mesi", resp_mesi, 0);
    lookup(14'd9, 12'h025);
    chk("post_rst_lookup", resp_hit, 0);
    upd(14'd10, 3'd0, 4'd7, 2'd0);
    chk("dropped_req_mesi", resp_mesi, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/l2_set_array.md
Name: l2_set_array

Overview:
- 8-way set-associative tag/state store for the split L2 cache.
- Holds per-line tag and MESI state, plus a per-set 7-bit tree pseudo-LRU.
- Serves single-operation requests from the L2 trace/command controller: tag write, LRU touch, MESI update, victim search, eviction, lookup.
- Contains no data storage; the controller sequences all operations.

Parameters:
- INDEX_BITS, 14, set index width (16K sets).
- TAG_BITS, 12, tag width.
- OFFSET_BITS, 6, line offset width (64 B lines). Carried for address splitting only.
- WAYS, 8, associativity. Fixed; the PLRU encoding assumes 8.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request strobe, one operation per cycle.
- req_op  in  3  operation: 0 LOOKUP, 1 WRITE_TAG, 2 TOUCH_LRU, 3 UPDATE_MESI, 4 FIND_VICTIM, 5 EVICT, 6-7 reserved (no-op).
- req_index  in  INDEX_BITS  set index.
- req_way  in  3  target way (WRITE_TAG, TOUCH_LRU, UPDATE_MESI, EVICT).
- req_tag  in  TAG_BITS  tag (LOOKUP, WRITE_TAG).
- req_cmd  in  4  trace command for UPDATE_MESI: 0 L1 read, 1 L1 write, 2 ifetch, 3 snooped invalidate, 4 snooped read, 5 snooped write, 6 snooped RWIM.
- snoop_result  in  2  bus snoop result: 0 NOHIT, 1 HIT, 2 HITM.
- resp_valid  out  1  response strobe.
- resp_hit  out  1  LOOKUP hit.
- resp_way  out  3  hit way, or victim way for FIND_VICTIM.
- resp_mesi  out  2  MESI state of the addressed line after the operation: I=0, S=1, E=2, M=3.
- resp_tag  out  TAG_BITS  tag of resp_way.

Behaviour:
- Reset (async, rst_n low):
  - All MESI states go to I and all PLRU bits to 0.
  - Tag array is not reset.
  - resp_valid, resp_hit, resp_way, resp_mesi and resp_tag all go to 0.
  - A request in flight during reset is dropped.
- Timing:
  - Requests are sampled on the rising edge when req_valid=1.
  - The response is registered and appears the next cycle with resp_valid high for exactly one cycle.
  - The controller may issue back-to-back requests. Each sees the state written by the previous one (write-first).
- LOOKUP:
  - Hit means some way has MESI≠I and a matching tag.
  - On hit: resp_hit=1 and resp_way=that way. If several ways match, the lowest numbered wins.
  - No state change.
- WRITE_TAG: tag[index][way] ← req_tag. MESI and LRU unchanged.
- TOUCH_LRU, with w = req_way:
  - b0 ← ~w[2]
  - b[1+w[2]] ← ~w[1]
  - b[3+2·w[2]+w[1]] ← ~w[0]
- UPDATE_MESI, next state from req_cmd and the current state:
  - cmd 0/2: I→S if snoop HIT or HITM, I→E if NOHIT; S/E/M unchanged.
  - cmd 1: →M from any state.
  - cmd 4: M/E→S; S stays S; I stays I.
  - cmd 3/5/6: →I.
  - Other commands: unchanged.
- FIND_VICTIM:
  - If any way in the set is I, return the lowest-numbered invalid way.
  - Otherwise return the PLRU victim: v2=b0, v1=b[1+v2], v0=b[3+2·v2+v1].
  - No state change.
- EVICT: MESI[index][way] ← I. Tag and LRU unchanged.
- Reserved ops produce resp_valid with all other fields 0.

Decomposition:
- Shared package l2_pkg holds:
  - the op enum, the MESI enum and the snoop-result enum;
  - the trace command codes;
  - the TAG/INDEX/OFFSET width constants.
- One sub-module, l2_plru8, is natural. It is purely combinational: it takes the 7 PLRU bits and an access way, and outputs the updated bits and the victim way.

Test Plan:
- Reset, then FIND_VICTIM on index 0 → way 0; LOOKUP of tag 0x111 → resp_hit=0.
- Index 0, for way i=0..7: WRITE_TAG tag=i, TOUCH_LRU way i, UPDATE_MESI cmd 0 with NOHIT. Then FIND_VICTIM → resp_way=000. Then EVICT way 0 → resp_mesi=I. Then LOOKUP tag 0 → miss.
- Continuing from the previous scenario, FIND_VICTIM → 000, because way 0 is invalid.
- Index 5, way 2, tag 0x111:
  - UPDATE_MESI cmd 0 with snoop HIT → S;
  - cmd 1 → M;
  - cmd 4 → S;
  - cmd 6 → I.
- All 8 ways valid; touch ways 7..0 in descending order → victim way 7. Touch 0,2,4,6 only after the full fill → victim way 1.
- Assert rst_n mid-sequence (asynchronously, between edges) → resp_valid drops immediately and all lines read I afterwards.
